// File: rtl/sdram_rd_capture.sv
// SDRAM read-data capture: tracks READ commands through a CAS-latency pipeline,
// samples one burst per READ and buffers the words in a first-word-fall-through FIFO.
module sdram_rd_capture #(
    parameter int DW      = 16,
    parameter int CL      = 3,
    parameter int BL      = 4,
    parameter int FIFO_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        sdram_cmd,
    input  logic [DW-1:0]     sdram_dq_in,
    output logic [DW-1:0]     rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [FIFO_AW:0]  fifo_count,
    output logic              burst_end,
    output logic              overflow,
    input  logic              clr_ovf
);
    localparam int          CW       = $clog2(BL + 1);
    localparam int          DEPTH    = 1 << FIFO_AW;
    localparam logic [3:0]  CMD_READ = 4'b0101;

    logic [CL:0]          pipe_q, pipe_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q, count_d;
    logic                 burst_end_q, ovf_q;
    logic [DW-1:0]        mem_q [DEPTH];

    logic start, cap, last, full, pop, wr, drop;

    // A flag in the last pipeline stage starts (or truncates and restarts) a burst,
    // and its first word is captured on the same edge.
    always_comb begin
        pipe_d = {pipe_q[CL-1:0], sdram_cmd == CMD_READ};
        start  = pipe_q[CL];
        cap    = start || (cnt_q != '0);
        if (start) begin
            cnt_d = CW'(BL - 1);
            last  = (BL == 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            last  = (cnt_q == CW'(1));
        end else begin
            cnt_d = cnt_q;
            last  = 1'b0;
        end
    end

    always_comb begin
        full = (count_q == (FIFO_AW + 1)'(DEPTH));
        pop  = rd_valid && rd_ready;
        wr   = cap && (!full || pop);
        drop = cap && full && !pop;
        case ({wr, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q      <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            burst_end_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            pipe_q      <= pipe_d;
            cnt_q       <= cnt_d;
            count_q     <= count_d;
            burst_end_q <= cap && last;
            if (wr)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (drop)
                ovf_q <= 1'b1;
            else if (clr_ovf)
                ovf_q <= 1'b0;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr)
            mem_q[wr_ptr_q] <= sdram_dq_in;
    end

    assign rd_valid   = (count_q != '0);
    assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_count = count_q;
    assign burst_end  = burst_end_q;
    assign overflow   = ovf_q;

endmodule

// File: doc/sdram_rd_capture.md
# sdram_rd_capture

Read-data capture and buffering stage downstream of the SDRAM controller top level. It watches the command nibble driven to the device and, for every READ command, samples the SDRAM data bus once the CAS latency has elapsed, for one full burst. Captured words go into a first-word-fall-through FIFO drained by the user logic through a valid/ready handshake. It is the consumer of everything the read path launches; the controller itself never samples `sdram_dq`.

## Interface
Parameters:
- `DW`, 16: data width; matches `sdram_dq`.
- `CL`, 3: CAS latency in `clk` cycles; legal values are 2 or 3.
- `BL`, 4: burst length in words; legal values are 1, 2, 4 or 8.
- `FIFO_AW`, 4: FIFO address width; depth is 2^FIFO_AW = 16.

Ports:
- `clk`  in  1  system clock; the device clock is `~clk`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sdram_cmd`  in  4  {cs_n, ras_n, cas_n, we_n} exactly as driven to the device.
- `sdram_dq_in`  in  DW  input side of the `sdram_dq` pad.
- `rd_data`  out  DW  FIFO head word; 0 whenever `rd_valid`=0.
- `rd_valid`  out  1  FIFO not empty.
- `rd_ready`  in  1  consumer accepts the head word.
- `fifo_count`  out  FIFO_AW+1  number of words stored, 0..16.
- `burst_end`  out  1  one-cycle pulse when the last word of a burst is captured.
- `overflow`  out  1  sticky; set when a captured word was dropped.
- `clr_ovf`  in  1  clears `overflow`.

## Operation
- **READ decode:** a READ is `sdram_cmd` == 4'b0101, sampled at clock edge n.
- **Latency pipeline:** a shift register of CL+1 stages carries the READ flag. When the flag reaches the last stage, the burst counter loads with BL.
- **Capture:** while the burst counter is non-zero, `sdram_dq_in` is pushed into the FIFO every edge and the counter decrements. Exactly BL words are captured per READ.
- **burst_end:** pulses in the cycle following the edge that captures the counter's last word (counter 1 → 0).
- **Back-to-back READs:** a READ issued every BL cycles gives a seamless capture stream with no idle cycle.
- **Burst truncation:** a later READ whose first word arrives while an earlier burst is still active truncates that burst. The counter reloads to BL at that edge, and `burst_end` pulses only for the later burst.
- **Other commands:** NOP, ACTIVE, PRECHARGE, AUTO REFRESH, WRITE and MRS are ignored. A WRITE does not cancel a pending READ in the pipeline.
- **FIFO storage:** circular buffer with write and read pointers that wrap modulo 16.
- **FIFO handshake:**
  - `rd_valid` = (`fifo_count` != 0).
  - Pop occurs when `rd_valid` && `rd_ready`.
  - `rd_ready` while empty has no effect.
- **Full FIFO:**
  - Push while full with a pop in the same cycle: both succeed and the count is unchanged.
  - Push while full with no pop: the word is dropped, `overflow` is set, and pointers and count are unchanged.
- **Overflow flag:** `clr_ovf` clears `overflow`. If a set and a clear occur in the same cycle, the set wins.
- **Simultaneous push and pop while empty:** the push is stored. The popped word is not taken, because `rd_valid` was 0.
- **Reset, asserted at any time:**
  - All outputs go to 0: `rd_valid`, `rd_data`, `fifo_count`, `burst_end`, `overflow`.
  - The pipeline, burst counter and pointers clear.
  - Bursts in flight are abandoned and no words from them are captured after release.
  - FIFO memory is not reset.

## Timing
- READ sampled at edge n → words captured at edges n+CL+1 through n+CL+BL.
- `rd_valid` rises after edge n+CL+1. With CL=3 this is cycle n+4.
- `fifo_count` changes on the edge after the push or pop. A concurrent push and pop leaves it unchanged.
- Pop is registered: the next head word appears on `rd_data` in the cycle after the accepting edge.
- `burst_end` is high for exactly one cycle, in the cycle following edge n+CL+BL.
- `overflow` is high from the edge after the dropped word until the edge after `clr_ovf`.
- Throughput: one word captured and one word popped per cycle.

## Test plan
- **Single burst:** CL=3, BL=4; READ at edge 10 with `sdram_dq_in` = 16'hA000+cycle.
  - Captures 16'hA00E through 16'hA011.
  - `burst_end` is high for exactly one cycle, the cycle after edge 17.
  - With `rd_ready` held 1, the words pop in order and `fifo_count` ends at 0.
- **Back-to-back READs:** READs at edges 10 and 14.
  - 8 contiguous captures at edges 14–21.
  - `burst_end` pulses twice.
- **Truncation:** READs at edges 10 and 12.
  - Burst 1 contributes 2 words (edges 14–15); burst 2 contributes 4 words (edges 16–19).
  - `fifo_count` reaches 6.
  - `burst_end` pulses once.
- **Overflow:** `rd_ready`=0; 5 bursts (20 words).
  - `fifo_count` = 16 with words 0–15 kept; `overflow` is set.
  - `clr_ovf` clears `overflow`.
  - While full, a push with a concurrent pop keeps `fifo_count` at 16.
- **Reset mid-burst:** `rst_n` asserted at edge 15 of a burst started by a READ at edge 10.
  - All outputs are 0 immediately.
  - No captures after release.
  - A new READ after release behaves as in the single-burst case.
- **Non-READ commands:** WRITE (4'b0100), AREF (4'b0001) and PRECHARGE (4'b0010) streams produce zero captures; `fifo_count` stays 0.
